// File: rtl/rv32_pkg.sv
// Shared constants for the RV32 front end (fetch stage and decode mux).
package rv32_pkg;

    localparam logic [31:0]  NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0]  DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned  PC_INCR          = 4;

endpackage

// File: rtl/rv32_sync_fifo.sv
// Synchronous FIFO with clear and same-cycle push/pop at any occupancy.
module rv32_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/rv32_fetch_unit.sv
// RV32 instruction fetch: PC generation, credit-limited imem requests,
// instruction buffering and stale-response discard after redirects.
module rv32_fetch_unit
    import rv32_pkg::*;
#(
    parameter int unsigned           INSTRUCTION_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH        = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC          = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned           FIFO_DEPTH        = 2
) (
    input  logic                         clk_in,
    input  logic                         reset_in,
    input  logic                         redirect_in,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc_in,
    output logic                         imem_req_valid_out,
    input  logic                         imem_req_ready_in,
    output logic [ADDR_WIDTH-1:0]        imem_addr_out,
    input  logic                         imem_rsp_valid_in,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rsp_data_in,
    output logic                         instr_valid_out,
    input  logic                         instr_ready_in,
    output logic [INSTRUCTION_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]        pc_out,
    output logic                         flush_out
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = ADDR_WIDTH + INSTRUCTION_WIDTH;

    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [CNT_W-1:0]      discard;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      outstanding_next;
    logic [CNT_W-1:0]      occupancy;
    logic [SUM_W-1:0]      credit_used;
    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic [ENTRY_W-1:0]    head;
    logic                  pop;
    logic                  accept;
    logic                  rsp;
    logic                  keep_rsp;

    // A request is only issued when a buffer slot is already reserved for it.
    assign pop                = instr_valid_out && instr_ready_in;
    assign credit_used        = SUM_W'(outstanding) + SUM_W'(occupancy) - SUM_W'(pop);
    assign imem_req_valid_out = !reset_in && (credit_used < SUM_W'(FIFO_DEPTH));
    assign imem_addr_out      = pc_reg;
    assign accept             = imem_req_valid_out && imem_req_ready_in;

    // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
    assign rsp              = imem_rsp_valid_in && (outstanding != '0);
    assign keep_rsp         = rsp && (discard == '0) && !redirect_in;
    assign outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(rsp);

    assign instr_valid_out = !reset_in && (occupancy != '0);
    assign flush_out       = !instr_valid_out;
    assign instr_out       = instr_valid_out ? head[INSTRUCTION_WIDTH-1:0]
                                             : INSTRUCTION_WIDTH'(NOP_INSTR);
    assign pc_out          = instr_valid_out ? head[ENTRY_W-1 -: ADDR_WIDTH] : '0;

    // The PC side-queue occupancy doubles as the outstanding-request count.
    rv32_sync_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk   (clk_in),
        .reset (reset_in),
        .clear (1'b0),
        .push  (accept),
        .wdata (pc_reg),
        .pop   (rsp),
        .rdata (rsp_pc),
        .count (outstanding)
    );

    rv32_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_buf (
        .clk   (clk_in),
        .reset (reset_in),
        .clear (redirect_in),
        .push  (keep_rsp),
        .wdata ({rsp_pc, imem_rsp_data_in}),
        .pop   (pop),
        .rdata (head),
        .count (occupancy)
    );

    // PC and discard tracking; a redirect drops everything still in flight.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            pc_reg  <= RESET_PC;
            discard <= '0;
        end else if (redirect_in) begin
            pc_reg  <= redirect_pc_in & ~ADDR_WIDTH'(3);
            discard <= outstanding_next;
        end else begin
            if (accept) begin
                pc_reg <= pc_reg + ADDR_WIDTH'(PC_INCR);
            end
            if (rsp && (discard != '0)) begin
                discard <= discard - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Scoreboard bench for rv32_fetch_unit with a latency-programmable memory model.
`timescale 1ns/1ps
module tb_rv32_fetch_unit;

    localparam int unsigned DEPTH   = 2;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam int          LIVE    = 0;
    localparam int          DISCARD = 1;
    localparam int          ORPHAN  = 2;

    logic        clk_in = 1'b0;
    logic        reset_in, redirect_in, imem_req_ready_in, imem_rsp_valid_in, instr_ready_in;
    logic [31:0] redirect_pc_in, imem_rsp_data_in;
    logic        imem_req_valid_out, instr_valid_out, flush_out;
    logic [31:0] imem_addr_out, instr_out, pc_out;

    always #5 clk_in = ~clk_in;

    rv32_fetch_unit #(
        .INSTRUCTION_WIDTH (32),
        .ADDR_WIDTH        (32),
        .RESET_PC          (RST_PC),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk_in             (clk_in),
        .reset_in           (reset_in),
        .redirect_in        (redirect_in),
        .redirect_pc_in     (redirect_pc_in),
        .imem_req_valid_out (imem_req_valid_out),
        .imem_req_ready_in  (imem_req_ready_in),
        .imem_addr_out      (imem_addr_out),
        .imem_rsp_valid_in  (imem_rsp_valid_in),
        .imem_rsp_data_in   (imem_rsp_data_in),
        .instr_valid_out    (instr_valid_out),
        .instr_ready_in     (instr_ready_in),
        .instr_out          (instr_out),
        .pc_out             (pc_out),
        .flush_out          (flush_out)
    );

    typedef struct { logic [31:0] addr; int unsigned due; int kind; } mem_req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    mem_req_t    memq[$];
    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned accepts = 0;
    int unsigned pops = 0;
    logic [31:0] model_pc = RST_PC;
    bit          mon_en = 1'b0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s actual=%0d required<=%0d (cycle %0d)", name, act, lim, cyc);
        end
    endtask

    // One clock of stimulus: memory responder, request bookkeeping, PC model.
    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                        input bit iready, input bit mready);
        int n_discard;
        bit acc;
        @(negedge clk_in);
        reset_in          = rst;
        redirect_in       = redir;
        redirect_pc_in    = rpc;
        instr_ready_in    = iready;
        imem_req_ready_in = mready;
        n_discard = 0;
        foreach (memq[i]) if (memq[i].kind == DISCARD) n_discard++;
        if (mon_en && !rst) chk_le("credit_bound", n_discard + expq.size(), DEPTH);
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid_in = 1'b1;
            imem_rsp_data_in  = memq[0].addr + 32'h100;
            void'(memq.pop_front());
        end else begin
            imem_rsp_valid_in = 1'b0;
            imem_rsp_data_in  = $urandom;
        end
        #1;
        if (rst) chk_eq("req_valid_in_reset", 32'(imem_req_valid_out), 32'd0);
        else if (imem_req_valid_out) chk_eq("req_addr", imem_addr_out, model_pc);
        acc = imem_req_valid_out && mready;
        if (instr_valid_out && iready && !rst) pops++;
        if (acc) begin
            accepts++;
            memq.push_back('{imem_addr_out, cyc + lat, LIVE});
            if (!redir && !rst) expq.push_back('{model_pc, model_pc + 32'h100});
        end
        foreach (memq[i]) begin
            if (rst) memq[i].kind = ORPHAN;
            else if (redir && memq[i].kind == LIVE) memq[i].kind = DISCARD;
        end
        @(posedge clk_in);
        cyc++;
        if (rst) model_pc = RST_PC;
        else if (redir) model_pc = rpc & ~32'h3;
        else if (acc) model_pc = model_pc + 32'd4;
    endtask

    // Monitor: compares every consumed instruction against the scoreboard.
    always @(negedge clk_in) begin
        exp_t e;
        #2;
        if (mon_en) begin
            chk_eq("flush_is_not_valid", 32'(flush_out), 32'(!instr_valid_out));
            if (!instr_valid_out) begin
                chk_eq("idle_instr", instr_out, NOP);
                chk_eq("idle_pc", pc_out, 32'd0);
            end
            if (instr_valid_out && instr_ready_in && !reset_in) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr pc=%h instr=%h required=none (cycle %0d)",
                             pc_out, instr_out, cyc);
                end else begin
                    e = expq.pop_front();
                    chk_eq("deliver_pc", pc_out, e.pc);
                    chk_eq("deliver_instr", instr_out, e.instr);
                end
            end
        end
        if (reset_in || redirect_in) expq.delete();
    end

    initial begin
        int unsigned a0, p0;
        reset_in = 1'b1; redirect_in = 1'b0; redirect_pc_in = '0;
        imem_req_ready_in = 1'b0; imem_rsp_valid_in = 1'b0; imem_rsp_data_in = '0;
        instr_ready_in = 1'b0;

        repeat (3) step(1, 0, 0, 0, 1);
        mon_en = 1'b1;
        #1;
        chk_eq("rst_instr_valid", 32'(instr_valid_out), 32'd0);
        chk_eq("rst_flush", 32'(flush_out), 32'd1);
        chk_eq("rst_instr", instr_out, NOP);
        chk_eq("rst_pc", pc_out, 32'd0);

        // Streaming at one instruction per cycle with 1-cycle memory.
        lat = 1; a0 = accepts; p0 = pops;
        repeat (20) step(0, 0, 0, 1, 1);
        chk_eq("stream_accepts", accepts - a0, 32'd20);
        chk_eq("stream_pops", pops - p0, 32'd18);

        // Decode stall: requests must stop once the buffer is committed.
        repeat (10) step(0, 0, 0, 0, 1);
        #1;
        chk_eq("stall_req_valid", 32'(imem_req_valid_out), 32'd0);
        chk_eq("stall_instr_valid", 32'(instr_valid_out), 32'd1);
        repeat (10) step(0, 0, 0, 1, 1);

        // Redirect with slow memory and two requests in flight.
        lat = 3;
        repeat (6) step(0, 0, 0, 1, 1);
        step(0, 1, 32'h0000_1002, 1, 1);
        repeat (12) step(0, 0, 0, 1, 1);

        // Redirect coinciding with a response and an accepted request.
        lat = 1;
        repeat (5) step(0, 0, 0, 1, 1);
        step(0, 1, 32'h0000_2000, 1, 1);
        repeat (8) step(0, 0, 0, 1, 1);

        // PC wrap past the top of the address space.
        step(0, 1, 32'hFFFF_FFF8, 1, 1);
        repeat (8) step(0, 0, 0, 1, 1);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 4);
            step(0, $urandom_range(0, 99) < 4, $urandom,
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75);
        end

        // Reset with a loaded buffer and one request outstanding.
        lat = 2;
        repeat (10) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        #1;
        chk_eq("post_rst_instr_valid", 32'(instr_valid_out), 32'd0);
        chk_eq("post_rst_flush", 32'(flush_out), 32'd1);
        chk_eq("post_rst_instr", instr_out, NOP);
        repeat (10) step(0, 0, 0, 1, 1);

        // Drain: no new requests, everything in flight must be delivered.
        lat = 1;
        repeat (10) step(0, 0, 0, 1, 0);
        #1;
        chk_eq("drain_expected_left", expq.size(), 32'd0);
        chk_eq("drain_mem_left", memq.size(), 32'd0);
        chk_eq("drain_instr_valid", 32'(instr_valid_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
